// File: rtl/modulation_multiplier_pipe_if.sv
// Sample stream into and product stream out of the modulation multiplier.
// Valid-only stream: no ready; a sample is transferred on every clock edge where din_valid (or dout_valid) is high.
interface modulation_multiplier_pipe_if #(
    parameter int INT_WIDTH   = 8,
    parameter int MOD_WIDTH   = 8,
    parameter int PHASE_WIDTH = 8
);
    logic                           din_valid;
    logic [INT_WIDTH-1:0]           intensity_in;
    logic [PHASE_WIDTH-1:0]         phase_in;
    logic [INT_WIDTH+MOD_WIDTH-1:0] intensity_out;
    logic [PHASE_WIDTH-1:0]         phase_out;
    logic                           dout_valid;
    logic                           dout_last;

    modport master (
        output din_valid, intensity_in, phase_in,
        input  intensity_out, phase_out, dout_valid, dout_last
    );

    modport slave (
        input  din_valid, intensity_in, phase_in,
        output intensity_out, phase_out, dout_valid, dout_last
    );
endinterface

// File: rtl/modulation_multiplier_pipe.sv
// Per-transducer modulation stage: delayed modulation address, memory read, intensity*modulation product.
// Define MOD_DELAY_EN to enable the per-transducer delay / cycle wrap address path.
module modulation_multiplier_pipe #(
    parameter int DEPTH        = 249,
    parameter int INT_WIDTH    = 8,
    parameter int MOD_WIDTH    = 8,
    parameter int PHASE_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 15,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            cycle_m,
    input  logic [ADDR_WIDTH-1:0]            idx,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] delay_m,
    output logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [MOD_WIDTH-1:0]             m_data,
    output logic                             frame_err,
    output logic                             dbg_state,
    modulation_multiplier_pipe_if.slave      stream
);
    localparam int LATENCY = BRAM_LATENCY + 4;
    localparam int INT_DLY = BRAM_LATENCY + 2;
    localparam int PW      = INT_WIDTH + MOD_WIDTH;
    localparam int CH_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic [ADDR_WIDTH-1:0]   idx_lat;
    logic [ADDR_WIDTH-1:0]   idx_eff;

    // The first sample of a frame uses the live idx, later samples the latched copy.
    assign idx_eff   = (state == IDLE) ? idx : idx_lat;
    assign dbg_state = state;

`ifdef MOD_DELAY_EN
    logic [ADDR_WIDTH-1:0]   cycle_lat;
    logic [ADDR_WIDTH-1:0]   cycle_eff;
    logic [ADDR_WIDTH:0]     diff_q;
    logic [ADDR_WIDTH-1:0]   cyc_q;
    logic [ADDR_WIDTH-1:0]   wrapped;

    assign cycle_eff = (state == IDLE) ? cycle_m : cycle_lat;
    assign wrapped   = diff_q[ADDR_WIDTH-1:0] + cyc_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_lat <= '0;
            diff_q    <= '0;
            cyc_q     <= '0;
            m_addr    <= '0;
        end else begin
            if (state == IDLE && stream.din_valid)
                cycle_lat <= cycle_m;
            diff_q <= {1'b0, idx_eff} - {1'b0, delay_m[ch]};
            cyc_q  <= cycle_eff;
            m_addr <= diff_q[ADDR_WIDTH] ? wrapped : diff_q[ADDR_WIDTH-1:0];
        end
    end
`else
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    unused_cfg;

    assign unused_cfg = ^{cycle_m, delay_m};

    // Two plain registers keep the address timing identical to the delay build.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            m_addr <= '0;
        end else begin
            addr_q <= idx_eff;
            m_addr <= addr_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            idx_lat   <= '0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stream.din_valid) begin
                        idx_lat <= idx;
                        if (DEPTH > 1) begin
                            ch    <= CH_W'(1);
                            state <= RUN;
                        end else begin
                            ch <= '0;
                        end
                    end
                end
                RUN: begin
                    if (stream.din_valid) begin
                        if (ch == LAST_CH) begin
                            ch    <= '0;
                            state <= IDLE;
                        end else begin
                            ch <= ch + CH_W'(1);
                        end
                    end else begin
                        frame_err <= 1'b1;
                        ch        <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ch    <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [LATENCY-1:0]     v_sr;
    logic [LATENCY-1:0]     l_sr;
    logic [INT_WIDTH-1:0]   int_sr [INT_DLY];
    logic [PHASE_WIDTH-1:0] ph_sr  [LATENCY-1];
    logic [PW-1:0]          prod_q;
    logic [PW-1:0]          int_out_q;
    logic [PHASE_WIDTH-1:0] ph_out_q;
    logic                   sample_last;

    assign sample_last = stream.din_valid && (ch == LAST_CH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sr      <= '0;
            l_sr      <= '0;
            prod_q    <= '0;
            int_out_q <= '0;
            ph_out_q  <= '0;
            for (int i = 0; i < INT_DLY; i++) int_sr[i] <= '0;
            for (int i = 0; i < LATENCY - 1; i++) ph_sr[i] <= '0;
        end else begin
            v_sr      <= {v_sr[LATENCY-2:0], stream.din_valid};
            l_sr      <= {l_sr[LATENCY-2:0], sample_last};
            int_sr[0] <= stream.intensity_in;
            for (int i = 1; i < INT_DLY; i++) int_sr[i] <= int_sr[i-1];
            ph_sr[0]  <= stream.phase_in;
            for (int i = 1; i < LATENCY - 1; i++) ph_sr[i] <= ph_sr[i-1];
            // Intensity arrives at the multiplier in the same cycle as the memory data for its address.
            prod_q    <= PW'(int_sr[INT_DLY-1]) * PW'(m_data);
            if (v_sr[LATENCY-2]) begin
                int_out_q <= prod_q;
                ph_out_q  <= ph_sr[LATENCY-2];
            end
        end
    end

    assign stream.dout_valid    = v_sr[LATENCY-1];
    assign stream.dout_last     = l_sr[LATENCY-1];
    assign stream.intensity_out = int_out_q;
    assign stream.phase_out     = ph_out_q;
endmodule
